// File: rtl/sargantana_icache_pkg.sv
// Shared types for the Sargantana instruction-cache tag array.
// The tag/set typedefs use the default array geometry (20-bit tags, 64 sets).
package sargantana_icache_pkg;

   localparam int unsigned DEF_TAG_WIDHT      = 20;
   localparam int unsigned DEF_TAG_DEPTH      = 64;
   localparam int unsigned DEF_TAG_ADDR_WIDHT = $clog2(DEF_TAG_DEPTH);

   // FLUSH is the reset state: coming out of reset is itself a sweep.
   typedef enum logic {
      FLUSH = 1'b0,
      IDLE  = 1'b1
   } itag_state_t;

   typedef logic [DEF_TAG_WIDHT-1:0]      tag_t;
   typedef logic [DEF_TAG_ADDR_WIDHT-1:0] set_idx_t;

endpackage

// File: rtl/sargantana_itag_way_bank.sv
// One way of the tag array: synchronous single-port store holding
// {parity?, vbit, tag} per set, with a registered read port.
// The contents are not reset (SRAM-like); only the read register is.
// A read and a write to the same set in one cycle return the old word.
module sargantana_itag_way_bank
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned DATA_W = 21,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage write port.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
   end

   // Registered read; holds its value until the next read.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rdata_o <= '0;
      end else if (re_i) begin
         rdata_o <= mem[addr_i];
      end
   end

endmodule

// File: rtl/sargantana_itag_array.sv
// Instruction-cache tag array: one bank per way, one-cycle registered
// lookup with tag compare and hit vector, and a set-per-cycle flush sweep.
// Optional feature macro: ITAG_PARITY_EN (per-entry even parity over
// {vbit, tag}; a parity error masks that way's valid and hit).
//
// Handshake: ready_o is a registered level. A rd_req_i/wr_req_i is taken
// only on a cycle where the FSM is IDLE (ready_o=1) and flush_i is low;
// otherwise it is dropped with no side effect. There is no backpressure
// beyond ready_o and no response valid: read results appear one cycle
// after an accepted read and hold until the next accepted read.
module sargantana_itag_array
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned ICACHE_N_WAY   = 4,
   parameter int unsigned TAG_DEPTH      = 64,
   parameter int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
   parameter int unsigned TAG_WIDHT      = 20
) (
   input  logic                                   clk_i,
   input  logic                                   rstn_i,
   input  logic                                   rd_req_i,
   input  logic                                   wr_req_i,
   input  logic [ICACHE_N_WAY-1:0]                wr_way_i,
   input  logic                                   vbit_i,
   input  logic                                   flush_i,
   input  logic [TAG_ADDR_WIDHT-1:0]              addr_i,
   input  logic [TAG_WIDHT-1:0]                   data_i,
   input  logic [TAG_WIDHT-1:0]                   cmp_tag_i,
   output logic                                   ready_o,
   output logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tag_way_o,
   output logic [ICACHE_N_WAY-1:0]                vbit_o,
   output logic [ICACHE_N_WAY-1:0]                hit_way_o,
   output logic                                   hit_o,
   output logic                                   flush_done_o,
   output logic [ICACHE_N_WAY-1:0]                parity_err_o,
   output itag_state_t                            dbg_state_o
);

`ifdef ITAG_PARITY_EN
   localparam int unsigned PAR_W = 1;
`else
   localparam int unsigned PAR_W = 0;
`endif
   localparam int unsigned BANK_W = PAR_W + 1 + TAG_WIDHT;
   localparam logic [TAG_ADDR_WIDHT-1:0] LAST_SET = TAG_ADDR_WIDHT'(TAG_DEPTH - 1);

   itag_state_t                 state_q;
   logic [TAG_ADDR_WIDHT-1:0]   cnt_q;
   logic                        ready_q;
   logic                        done_q;
   logic                        rd_valid_q;
   logic [TAG_WIDHT-1:0]        cmp_q;

   logic                        flushing;
   logic                        accept;
   logic                        rd_acc;
   logic                        wr_acc;
   logic [BANK_W-1:0]           wr_word;
   logic [TAG_ADDR_WIDHT-1:0]   bank_addr;
   logic [BANK_W-1:0]           bank_wdata;
   logic [ICACHE_N_WAY-1:0]     bank_we;
   logic [ICACHE_N_WAY-1:0][BANK_W-1:0] rdata;

   assign flushing = (state_q == FLUSH);
   // flush_i wins over any rd/wr presented in the same IDLE cycle.
   assign accept   = (state_q == IDLE) && !flush_i;
   assign rd_acc   = accept && rd_req_i;
   assign wr_acc   = accept && wr_req_i;

   // Refill word, with even parity over {vbit, tag} when enabled.
   always_comb begin
      wr_word = '0;
`ifdef ITAG_PARITY_EN
      wr_word = {^{vbit_i, data_i}, vbit_i, data_i};
`else
      wr_word = {vbit_i, data_i};
`endif
   end

   // The sweep owns the bank address and writes an all-zero entry,
   // which is also parity-consistent.
   assign bank_addr  = flushing ? cnt_q : addr_i;
   assign bank_wdata = flushing ? '0 : wr_word;

   for (genvar w = 0; w < ICACHE_N_WAY; w++) begin : g_way
      assign bank_we[w] = flushing || (wr_acc && wr_way_i[w]);

      sargantana_itag_way_bank #(
         .DATA_W (BANK_W),
         .DEPTH  (TAG_DEPTH),
         .ADDR_W (TAG_ADDR_WIDHT)
      ) u_bank (
         .clk_i   (clk_i),
         .rstn_i  (rstn_i),
         .we_i    (bank_we[w]),
         .re_i    (rd_acc),
         .addr_i  (bank_addr),
         .wdata_i (bank_wdata),
         .rdata_o (rdata[w])
      );
   end

   // Control FSM: sweep counter, registered ready and flush-done pulse.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= FLUSH;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            FLUSH: begin
               if (flush_i) begin
                  // Restart the sweep; the aborted one never signals done.
                  cnt_q <= '0;
               end else if (cnt_q == LAST_SET) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + TAG_ADDR_WIDHT'(1);
               end
            end
            IDLE: begin
               if (flush_i) begin
                  state_q <= FLUSH;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= FLUSH;
               cnt_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Lookup context: compare tag captured with the request, and whether the
   // held read data may still report valid (cleared when a flush starts).
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_valid_q <= 1'b0;
         cmp_q      <= '0;
      end else if ((state_q == IDLE) && flush_i) begin
         rd_valid_q <= 1'b0;
      end else if (rd_acc) begin
         rd_valid_q <= 1'b1;
         cmp_q      <= cmp_tag_i;
      end
   end

   // Per-way output decode from the registered bank read data.
   always_comb begin
      tag_way_o    = '0;
      vbit_o       = '0;
      hit_way_o    = '0;
      parity_err_o = '0;
      for (int w = 0; w < ICACHE_N_WAY; w++) begin
         tag_way_o[w] = rdata[w][TAG_WIDHT-1:0];
`ifdef ITAG_PARITY_EN
         parity_err_o[w] = ^rdata[w];
`endif
         vbit_o[w]    = rd_valid_q && rdata[w][TAG_WIDHT] && !parity_err_o[w];
         hit_way_o[w] = vbit_o[w] && (rdata[w][TAG_WIDHT-1:0] == cmp_q);
      end
   end

   assign hit_o        = |hit_way_o;
   assign ready_o      = ready_q;
   assign flush_done_o = done_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sargantana_itag_array.sv
// Bench for sargantana_itag_array: directed scenarios plus random traffic,
// checked against a set-array reference model through an expected queue.
module tb_sargantana_itag_array;
   import sargantana_icache_pkg::*;

   localparam int NW    = 4;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int TW    = 20;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic                   rd_req, wr_req, vbit_in, flush;
   logic [NW-1:0]          wr_way;
   logic [AW-1:0]          addr;
   logic [TW-1:0]          data, cmp_tag;
   logic                   ready, hit, flush_done;
   logic [NW-1:0][TW-1:0]  tag_way;
   logic [NW-1:0]          vbit_out, hit_way, parity_err;
   itag_state_t            dbg_state;

   sargantana_itag_array #(
      .ICACHE_N_WAY (NW),
      .TAG_DEPTH    (DEPTH),
      .TAG_WIDHT    (TW)
   ) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .rd_req_i     (rd_req),
      .wr_req_i     (wr_req),
      .wr_way_i     (wr_way),
      .vbit_i       (vbit_in),
      .flush_i      (flush),
      .addr_i       (addr),
      .data_i       (data),
      .cmp_tag_i    (cmp_tag),
      .ready_o      (ready),
      .tag_way_o    (tag_way),
      .vbit_o       (vbit_out),
      .hit_way_o    (hit_way),
      .hit_o        (hit),
      .flush_done_o (flush_done),
      .parity_err_o (parity_err),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- reference model ----------------
   bit   m_v   [NW][DEPTH];
   tag_t m_tag [NW][DEPTH];
   bit   m_bad [NW][DEPTH];
   int   sweep_left;            // cycles of flush still to run; 0 = ready
   tag_t out_tag [NW];
   bit   out_v   [NW];
   bit   out_perr[NW];
   tag_t out_cmp;

   typedef struct {
      int                    due;
      logic                  ready;
      logic                  done;
      logic                  hit;
      logic [NW-1:0]         vbit;
      logic [NW-1:0]         hitw;
      logic [NW-1:0]         perr;
      logic [NW-1:0][TW-1:0] tags;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic clear_array();
      for (int w = 0; w < NW; w++)
         for (int s = 0; s < DEPTH; s++) begin
            m_v[w][s] = 1'b0; m_tag[w][s] = '0; m_bad[w][s] = 1'b0;
         end
   endtask

   task automatic model_reset();
      clear_array();
      sweep_left = DEPTH;
      out_cmp = '0;
      for (int w = 0; w < NW; w++) begin
         out_tag[w] = '0; out_v[w] = 1'b0; out_perr[w] = 1'b0;
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge: applies inputs for the next edge,
   // advances the model across that edge and queues the expected outputs.
   task automatic drive_cycle(input bit rd, input bit wr, input logic [NW-1:0] way,
                              input bit v, input bit fl, input int a,
                              input tag_t d, input tag_t c);
      exp_t e;
      bit   done_n = 1'b0;
      rd_req = rd; wr_req = wr; wr_way = way; vbit_in = v; flush = fl;
      addr = a[AW-1:0]; data = d; cmp_tag = c;
      if (sweep_left == 0) begin
         if (fl) begin
            sweep_left = DEPTH;
            clear_array();
            for (int w = 0; w < NW; w++) out_v[w] = 1'b0;
         end else begin
            if (rd) begin
               for (int w = 0; w < NW; w++) begin
                  out_tag[w]  = m_tag[w][a];
                  out_v[w]    = m_v[w][a];
                  out_perr[w] = m_bad[w][a];
               end
               out_cmp = c;
            end
            if (wr)
               for (int w = 0; w < NW; w++)
                  if (way[w]) begin
                     m_tag[w][a] = d; m_v[w][a] = v; m_bad[w][a] = 1'b0;
                  end
         end
      end else begin
         if (fl) sweep_left = DEPTH;
         else begin
            sweep_left--;
            if (sweep_left == 0) done_n = 1'b1;
         end
      end
      e.due   = cyc + 1;
      e.ready = (sweep_left == 0);
      e.done  = done_n;
      for (int w = 0; w < NW; w++) begin
         e.tags[w] = out_tag[w];
         e.perr[w] = out_perr[w];
         e.vbit[w] = out_v[w] && !out_perr[w];
         e.hitw[w] = e.vbit[w] && (out_tag[w] == out_cmp);
      end
      e.hit = |e.hitw;
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, 0, 0, 0, '0, '0);
   endtask

   task automatic rd_set(input int a, input tag_t c);
      drive_cycle(1, 0, '0, 0, 0, a, '0, c);
   endtask

   task automatic wr_set(input int a, input logic [NW-1:0] way, input bit v, input tag_t d);
      drive_cycle(0, 1, way, v, 0, a, d, '0);
   endtask

   function automatic bit diff(string name, logic [NW*TW-1:0] got, logic [NW*TW-1:0] want);
      if (got !== want) begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
         return 1'b1;
      end
      return 1'b0;
   endfunction

   // Asynchronous reset: outputs must clear without waiting for a clock.
   task automatic do_reset();
      bit bad = 1'b0;
      @(negedge clk); #1;
      rd_req = 0; wr_req = 0; flush = 0;
      rstn = 1'b0;
      exp_q.delete();
      #1;
      bad |= diff("reset_ready", ready, '0);
      bad |= diff("reset_done", flush_done, '0);
      bad |= diff("reset_tags", tag_way, '0);
      bad |= diff("reset_vbit", vbit_out, '0);
      bad |= diff("reset_hitway", hit_way, '0);
      bad |= diff("reset_hit", hit, '0);
      bad |= diff("reset_perr", parity_err, '0);
      tests++;
      if (bad) fails++;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   // ---------------- scoreboard monitor ----------------
   exp_t mon_e;
   bit   mon_bad;
   always @(negedge clk) begin
      if (rstn) begin
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_bad = 1'b0;
            if (mon_e.due != cyc) begin
               $display("FAIL sb_stale: got due %0d expected %0d", mon_e.due, cyc);
               mon_bad = 1'b1;
            end
            mon_bad |= diff("ready", ready, mon_e.ready);
            mon_bad |= diff("flush_done", flush_done, mon_e.done);
            mon_bad |= diff("tag_way", tag_way, mon_e.tags);
            mon_bad |= diff("vbit", vbit_out, mon_e.vbit);
            mon_bad |= diff("hit_way", hit_way, mon_e.hitw);
            mon_bad |= diff("hit", hit, mon_e.hit);
            mon_bad |= diff("parity_err", parity_err, mon_e.perr);
            tests++;
            if (mon_bad) fails++;
         end
      end
   end

   function automatic tag_t pick_tag();
      case ($urandom_range(0, 3))
         0:       return 20'hABCDE;
         1:       return 20'h11111;
         2:       return 20'h22222;
         default: return tag_t'($urandom);
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rd_req = 0; wr_req = 0; wr_way = '0; vbit_in = 0; flush = 0;
      addr = '0; data = '0; cmp_tag = '0;
      model_reset();
      do_reset();

      // Power-on sweep, then an empty lookup.
      idle(66);
      rd_set(9, '0);
      idle(1);

      // Single-way refill and hit.
      wr_set(5, 4'b0100, 1, 20'hABCDE);
      rd_set(5, 20'hABCDE);
      idle(1);

      // Read-before-write on the same set.
      wr_set(7, 4'b1111, 1, 20'h22222);
      drive_cycle(1, 1, 4'b1111, 1, 0, 7, 20'h11111, 20'h22222);
      rd_set(7, 20'h11111);
      wr_set(8, 4'b0000, 1, 20'h33333);   // no way selected: nothing written
      rd_set(8, 20'h33333);
      idle(1);

      // Fill every set, flush, restart the flush at cycle 30 of the sweep.
      for (int s = 0; s < DEPTH; s++) wr_set(s, 4'($urandom), 1, pick_tag());
      rd_set(3, 20'hABCDE);
      drive_cycle(1, 1, 4'b1111, 1, 1, 4, 20'h12345, 20'h12345);
      for (int i = 0; i < 29; i++)
         drive_cycle($urandom_range(0, 1), $urandom_range(0, 1), 4'b1111, 1, 0,
                     $urandom_range(0, DEPTH - 1), pick_tag(), pick_tag());
      drive_cycle(0, 0, '0, 0, 1, 0, '0, '0);
      for (int i = 0; i < 66; i++)
         drive_cycle($urandom_range(0, 1), $urandom_range(0, 1), 4'b1111, 1, 0,
                     $urandom_range(0, DEPTH - 1), pick_tag(), pick_tag());
      for (int s = 0; s < 4; s++) rd_set(s, '0);

      // Reset in the middle of a read, then in the middle of a sweep.
      wr_set(2, 4'b0001, 1, 20'h0F0F0);
      rd_set(2, 20'h0F0F0);
      do_reset();
      idle(20);
      do_reset();
      idle(66);

`ifdef ITAG_PARITY_EN
      wr_set(3, 4'b0010, 1, 20'h12345);
      dut.g_way[1].u_bank.mem[3][TW+1] = ~dut.g_way[1].u_bank.mem[3][TW+1];
      m_bad[1][3] = 1'b1;
      rd_set(3, 20'h12345);
      idle(1);
`endif

      // Random traffic.
      for (int i = 0; i < 2500; i++)
         drive_cycle($urandom_range(0, 1), ($urandom_range(0, 9) < 4), 4'($urandom),
                     $urandom_range(0, 3) != 0, ($urandom_range(0, 149) == 0),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7),
                     pick_tag(), pick_tag());

      idle(2);
      @(negedge clk); #1;
      tests++;
      if (exp_q.size() != 0) begin
         $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
         fails++;
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
